addsub_issue_stage: RTL and testbench
=====================================

# addsub_issue_stage

Buffered issue stage for the 64-bit split/unified adder. It accepts add/subtract operations over a valid/ready handshake and queues them in a small FIFO. Each operation is decoded into the `mode`/`sub_uni`/`sub_lo`/`sub_hi` controls of an internal `adder64` instance. The stage registers the sum and status flags into an output slot with its own valid/ready handshake, so upstream operand fetch and downstream writeback are decoupled from the adder.

## Interface
- `DEPTH`, default 2: input FIFO entries; must be a power of 2 and at least 2.
- `TAG_W`, default 4: width of the opaque tag carried alongside each operation.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_valid`  in  1  upstream offers an operation.
- `in_ready`  out  1  FIFO can accept; equals (count < DEPTH).
- `in_op`  in  3  operation code, see Operation.
- `in_a`, `in_b`  in  64  operands.
- `in_tag`  in  TAG_W  tag, returned unchanged with the result.
- `out_valid`  out  1  result slot holds a result.
- `out_ready`  in  1  downstream consumes the slot.
- `out_sum`  out  64  adder64 sum.
- `out_cout`  out  1  adder64 cout.
- `out_zero_lo`, `out_zero_hi`  out  1  sum[31:0]==0, sum[63:32]==0.
- `out_err`  out  1  op code was illegal.
- `out_tag`  out  TAG_W  tag of the result.

## Operation
Op decode (mode, sub_uni, sub_lo, sub_hi):
- 000 ADD64: 1,0,x,x
- 001 SUB64: 1,1,x,x
- 010 ADD2x32: 0,x,0,0
- 011 SUB2x32: 0,x,1,1
- 100 ADDLO_SUBHI: 0,x,0,1
- 101 SUBLO_ADDHI: 0,x,1,0
- 110, 111 illegal: the operation is accepted; the result has out_sum=0, out_cout=0, out_zero_lo=1, out_zero_hi=1, out_err=1.
- Every don't-care (x) control is driven to 0.

FIFO and handshake:
- Push when in_valid && in_ready.
- The FIFO head drives adder64 combinationally.
- The result slot loads when the FIFO is non-empty and (!out_valid || out_ready). The head pops on the same edge.
- Push and pop on the same edge leave count unchanged. Read and write pointers wrap modulo DEPTH.

Output slot:
- out_valid clears when out_ready is high and no new load occurs on that edge.
- Output fields are held stable while out_valid && !out_ready.

Flag semantics:
- Unified SUB64: out_cout=1 means borrow (a < b unsigned).
- Split modes: out_cout is the raw high-lane carry. For a high-lane subtract, 1 means a_hi >= b_hi.
- The low-lane carry never reaches the high lane in split mode.

Ordering: results leave strictly in acceptance order. No operation is dropped or duplicated.

## Timing
- Reset, asynchronous, takes effect immediately:
  - count=0, both pointers=0, out_valid=0.
  - out_sum=0, out_cout=0, out_zero_lo=0, out_zero_hi=0, out_err=0, out_tag=0.
  - in_ready=1 once rst deasserts.
- Latency: an operation accepted at edge N into an empty stage presents out_valid=1 after edge N+1.
- Throughput: 1 operation per cycle with out_ready held high.
- in_ready depends only on count. It has no combinational path from out_ready, so a full FIFO does not accept in the same cycle as a pop.
- Full: with the slot stalled, the stage holds DEPTH+1 operations (DEPTH in the FIFO plus 1 in the slot), and in_ready=0.
- Reset mid-operation: all queued and slot contents are discarded. The first post-reset result is the first post-reset accepted operation.

## Test plan
- ADD64, a=0x00000000_FFFFFFFF, b=1 -> sum 0x00000001_00000000, cout 0, zero_lo 1, zero_hi 0, err 0.
- SUB64, a=0, b=1 -> sum 0xFFFFFFFF_FFFFFFFF, cout 1. SUB64 with a=5, b=5 -> sum 0, cout 0, both zero flags 1.
- ADD2x32, a=0x00000001_FFFFFFFF, b=0x00000001_00000001 -> sum 0x00000002_00000000, no cross-lane carry. SUB2x32, a=0x00000005_00000003, b=0x00000005_00000004 -> sum 0x00000000_FFFFFFFF, zero_hi 1, cout 1.
- Backpressure, DEPTH=2, out_ready=0, push tags 1,2,3 on consecutive cycles:
  - in_ready=0 after the third push.
  - Raise out_ready -> tags 1,2,3 emerge on consecutive cycles with held data.
  - in_ready returns to 1 one cycle after the first pop.
- Op 111, a=b=0xFFFF... -> sum 0, err 1, zero flags 1. The next legal op is unaffected.
- Assert rst for 1 cycle with 2 queued and 1 in the slot:
  - out_valid drops immediately and stays 0.
  - After release, a single ADD64 1+1 returns sum 2 two edges after acceptance.

Source files
------------

// File: rtl/addsub_issue_stage.sv
// rtl/addsub_issue_stage.sv - buffered issue stage (FIFO + registered result slot) around a split/unified 64-bit adder
module adder64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        mode,
    input  logic        sub_uni,
    input  logic        sub_lo,
    input  logic        sub_hi,
    output logic [63:0] sum,
    output logic        cout
);
    logic        sub_l;
    logic        sub_h;
    logic [31:0] b_lo;
    logic [31:0] b_hi;
    logic [32:0] lo_full;
    logic [32:0] hi_full;
    logic        cin_hi;

    // Subtraction is a + ~b + 1; in split mode the high lane takes its own +1 instead of the low carry.
    assign sub_l   = mode ? sub_uni : sub_lo;
    assign sub_h   = mode ? sub_uni : sub_hi;
    assign b_lo    = sub_l ? ~b[31:0]  : b[31:0];
    assign b_hi    = sub_h ? ~b[63:32] : b[63:32];
    assign lo_full = {1'b0, a[31:0]} + {1'b0, b_lo} + {32'd0, sub_l};
    assign cin_hi  = mode ? lo_full[32] : sub_h;
    assign hi_full = {1'b0, a[63:32]} + {1'b0, b_hi} + {32'd0, cin_hi};
    assign sum     = {hi_full[31:0], lo_full[31:0]};
    // Unified subtract reports borrow; split modes report the raw high-lane carry.
    assign cout    = (mode && sub_uni) ? ~hi_full[32] : hi_full[32];
endmodule

module addsub_issue_stage #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [63:0]      in_a,
    input  logic [63:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_sum,
    output logic             out_cout,
    output logic             out_zero_lo,
    output logic             out_zero_hi,
    output logic             out_err,
    output logic [TAG_W-1:0] out_tag
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [2:0]       op_mem  [DEPTH];
    logic [63:0]      a_mem   [DEPTH];
    logic [63:0]      b_mem   [DEPTH];
    logic [TAG_W-1:0] tag_mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic push;
    logic load;

    logic [2:0]  head_op;
    logic [63:0] head_a;
    logic [63:0] head_b;
    logic        mode;
    logic        sub_uni;
    logic        sub_lo;
    logic        sub_hi;
    logic        illegal;
    logic [63:0] add_sum;
    logic        add_cout;

    assign in_ready = (count < (AW+1)'(DEPTH));
    assign push     = in_valid && in_ready;
    assign load     = (count != '0) && (!out_valid || out_ready);

    assign head_op = op_mem[rd_ptr];
    assign head_a  = a_mem[rd_ptr];
    assign head_b  = b_mem[rd_ptr];

    always_comb begin
        mode    = 1'b0;
        sub_uni = 1'b0;
        sub_lo  = 1'b0;
        sub_hi  = 1'b0;
        illegal = 1'b0;
        case (head_op)
            3'b000: mode = 1'b1;
            3'b001: begin mode = 1'b1; sub_uni = 1'b1; end
            3'b010: ;
            3'b011: begin sub_lo = 1'b1; sub_hi = 1'b1; end
            3'b100: sub_hi = 1'b1;
            3'b101: sub_lo = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

    adder64 u_adder (
        .a       (head_a),
        .b       (head_b),
        .mode    (mode),
        .sub_uni (sub_uni),
        .sub_lo  (sub_lo),
        .sub_hi  (sub_hi),
        .sum     (add_sum),
        .cout    (add_cout)
    );

    // Payload storage needs no reset: entries are only read when count says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr]  <= in_op;
            a_mem[wr_ptr]   <= in_a;
            b_mem[wr_ptr]   <= in_b;
            tag_mem[wr_ptr] <= in_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            out_valid   <= 1'b0;
            out_sum     <= '0;
            out_cout    <= 1'b0;
            out_zero_lo <= 1'b0;
            out_zero_hi <= 1'b0;
            out_err     <= 1'b0;
            out_tag     <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (load) rd_ptr <= rd_ptr + 1'b1;
            case ({push, load})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (load) begin
                out_valid   <= 1'b1;
                out_tag     <= tag_mem[rd_ptr];
                out_err     <= illegal;
                out_sum     <= illegal ? 64'd0 : add_sum;
                out_cout    <= illegal ? 1'b0 : add_cout;
                out_zero_lo <= illegal ? 1'b1 : (add_sum[31:0] == 32'd0);
                out_zero_hi <= illegal ? 1'b1 : (add_sum[63:32] == 32'd0);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_addsub_issue_stage.sv
// tb/tb_addsub_issue_stage.sv - scoreboard testbench for addsub_issue_stage
module tb_addsub_issue_stage;
    localparam int TAG_W = 4;

    typedef struct packed {
        logic [63:0]      sum;
        logic             cout;
        logic             zlo;
        logic             zhi;
        logic             err;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_op = '0;
    logic [63:0]      in_a = '0;
    logic [63:0]      in_b = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [63:0]      out_sum;
    logic             out_cout;
    logic             out_zero_lo;
    logic             out_zero_hi;
    logic             out_err;
    logic [TAG_W-1:0] out_tag;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    addsub_issue_stage #(.DEPTH(2), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .out_cout    (out_cout),
        .out_zero_lo (out_zero_lo),
        .out_zero_hi (out_zero_hi),
        .out_err     (out_err),
        .out_tag     (out_tag)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [63:0] a,
                                   input logic [63:0] b, input logic [TAG_W-1:0] tag);
        exp_t        e;
        logic [64:0] wide;
        logic [32:0] hi;
        logic [31:0] lo;
        e = '0;
        e.tag = tag;
        case (op)
            3'd0: begin wide = {1'b0, a} + {1'b0, b}; e.sum = wide[63:0]; e.cout = wide[64]; end
            3'd1: begin e.sum = a - b; e.cout = (a < b); end
            3'd2, 3'd3, 3'd4, 3'd5: begin
                lo = (op == 3'd3 || op == 3'd5) ? a[31:0] - b[31:0] : a[31:0] + b[31:0];
                if (op == 3'd3 || op == 3'd4) begin
                    hi[31:0] = a[63:32] - b[63:32];
                    hi[32]   = (a[63:32] >= b[63:32]);
                end else begin
                    hi = {1'b0, a[63:32]} + {1'b0, b[63:32]};
                end
                e.sum = {hi[31:0], lo};
                e.cout = hi[32];
            end
            default: begin e.sum = 64'd0; e.cout = 1'b0; e.err = 1'b1; end
        endcase
        e.zlo = (e.sum[31:0] == 32'd0);
        e.zhi = (e.sum[63:32] == 32'd0);
        return e;
    endfunction

    // Monitor: compare the slot against the oldest expectation every valid cycle; pop on handshake.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got tag %0d with empty scoreboard", out_tag);
            end else begin
                if ({out_sum, out_cout, out_zero_lo, out_zero_hi, out_err, out_tag} !== sb[0]) begin
                    errors++;
                    $display("FAIL result: got sum=%h c=%b zl=%b zh=%b e=%b t=%0d expected sum=%h c=%b zl=%b zh=%b e=%b t=%0d",
                             out_sum, out_cout, out_zero_lo, out_zero_hi, out_err, out_tag,
                             sb[0].sum, sb[0].cout, sb[0].zlo, sb[0].zhi, sb[0].err, sb[0].tag);
                end
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [TAG_W-1:0] tag);
        int n = 0;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
        @(negedge clk);
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready stuck at 0 for tag %0d", tag);
        end else begin
            sb.push_back(model(op, a, b, tag));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin @(negedge clk); n++; end
        chk("drain_empty", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    bit rand_done;

    initial begin
        #12;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_sum", out_sum, 64'd0);
        chk("rst_flags", {59'd0, out_cout, out_zero_lo, out_zero_hi, out_err, 1'b0}, 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;

        // Directed cases; the first also checks the two-edge latency.
        out_ready = 1'b1;
        send(3'd0, 64'h00000000_FFFFFFFF, 64'd1, 4'd1);
        @(negedge clk);
        chk("lat_not_yet", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        chk("lat_valid", {63'd0, out_valid}, 64'd1);
        chk("add64_sum", out_sum, 64'h00000001_00000000);
        @(posedge clk); #1;
        send(3'd1, 64'd0, 64'd1, 4'd2);
        send(3'd1, 64'd5, 64'd5, 4'd3);
        send(3'd2, 64'h00000001_FFFFFFFF, 64'h00000001_00000001, 4'd4);
        send(3'd3, 64'h00000005_00000003, 64'h00000005_00000004, 4'd5);
        send(3'd4, 64'h00000003_00000001, 64'h00000004_00000002, 4'd6);
        send(3'd5, 64'h00000001_00000001, 64'h00000002_00000002, 4'd7);
        send(3'd7, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 4'd8);
        send(3'd6, 64'h12345678_9ABCDEF0, 64'd3, 4'd9);
        send(3'd0, 64'd7, 64'd8, 4'd10);
        drain();

        // Backpressure: fill FIFO plus slot, then release.
        out_ready = 1'b0;
        send(3'd0, 64'd10, 64'd1, 4'd1);
        send(3'd0, 64'd20, 64'd2, 4'd2);
        send(3'd0, 64'd30, 64'd3, 4'd3);
        @(negedge clk);
        chk("full_in_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        chk("full_hold_tag", 64'(out_tag), 64'd1);
        chk("full_hold_sum", out_sum, 64'd11);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_tag1", 64'(out_tag), 64'd1);
        chk("bp_ready_before_pop", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        chk("bp_tag2", {59'd0, out_valid, out_tag}, {59'd0, 1'b1, 4'd2});
        chk("bp_ready_after_pop", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        chk("bp_tag3", {59'd0, out_valid, out_tag}, {59'd0, 1'b1, 4'd3});
        @(negedge clk);
        chk("bp_empty", {63'd0, out_valid}, 64'd0);
        drain();

        // Reset with two queued and one in the slot.
        out_ready = 1'b0;
        send(3'd0, 64'd100, 64'd1, 4'd11);
        send(3'd0, 64'd200, 64'd1, 4'd12);
        send(3'd0, 64'd300, 64'd1, 4'd13);
        rst = 1'b1;
        sb.delete();
        #1;
        chk("midrst_valid_drop", {63'd0, out_valid}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_stays_low", {63'd0, out_valid}, 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(3'd0, 64'd1, 64'd1, 4'd14);
        @(negedge clk);
        chk("post_rst_not_yet", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        chk("post_rst_valid", {63'd0, out_valid}, 64'd1);
        chk("post_rst_sum", out_sum, 64'd2);
        @(posedge clk); #1;
        drain();

        // Randomised traffic with random downstream stalls.
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    logic [63:0] a;
                    logic [63:0] b;
                    a = {$urandom, $urandom};
                    b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
                    if ($urandom_range(0, 7) == 0) a[31:0] = 32'd0;
                    send(3'($urandom_range(0, 7)), a, b, TAG_W'(i));
                    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end
endmodule
